// File: rtl/ghost_move_scheduler.sv
// Round-robin arbiter sharing one ghostNextLoc engine among N_GHOSTS ghosts; IDLE->ISSUE->WAIT->WRITE per move.
// Optional ENG_TIMEOUT_EN: abort a WAIT after TIMEOUT cycles, hold the ghost in place and raise sticky err_timeout.
module ghost_move_scheduler #(
  parameter int                N_GHOSTS  = 4,
  parameter int                POS_W     = 10,
  parameter logic [POS_W-1:0]  RESET_POS = '0,
  parameter int                TIMEOUT   = 255,
  localparam int               GW        = (N_GHOSTS > 1) ? $clog2(N_GHOSTS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [N_GHOSTS-1:0]       i_req,
  input  logic [N_GHOSTS-1:0]       i_ghost_en,
  input  logic [N_GHOSTS*POS_W-1:0] i_cur_pos,
  input  logic [N_GHOSTS*POS_W-1:0] i_tgt_pos,
  output logic                      o_eng_start,
  output logic [POS_W-1:0]          o_eng_curr,
  output logic [POS_W-1:0]          o_eng_tgt,
  input  logic [POS_W-1:0]          i_eng_next,
  input  logic                      i_eng_done,
  input  logic                      i_eng_ready,
  output logic [N_GHOSTS*POS_W-1:0] o_next_pos,
  output logic [N_GHOSTS-1:0]       o_upd_valid,
  output logic [GW-1:0]             o_grant_id,
  output logic                      o_busy,
  output logic                      o_err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE} state_t;

  state_t                r_state, w_state_nxt;
  logic [N_GHOSTS-1:0]   r_pending;
  logic [GW-1:0]         r_ptr;
  logic [GW-1:0]         r_grant;
  logic [POS_W-1:0]      r_eng_curr;
  logic [POS_W-1:0]      r_eng_tgt;
  logic [POS_W-1:0]      r_next_pos [N_GHOSTS];

  logic [N_GHOSTS-1:0]   w_elig;
  logic [GW-1:0]         w_sel;
  logic                  w_sel_vld;
  logic [N_GHOSTS-1:0]   w_grant_oh;
  logic [N_GHOSTS-1:0]   w_issue_clr;
  logic                  w_timeout;
  logic                  w_grant;

  // Scan from ptr+N down to ptr+1 so the nearest eligible ghost after ptr wins.
  always_comb begin
    int idx;
    idx       = 0;
    w_elig    = r_pending & i_ghost_en;
    w_sel     = r_ptr;
    w_sel_vld = 1'b0;
    for (int k = N_GHOSTS; k >= 1; k--) begin
      idx = (int'(r_ptr) + k) % N_GHOSTS;
      if (w_elig[idx]) begin
        w_sel     = GW'(idx);
        w_sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    w_grant_oh          = '0;
    w_grant_oh[r_grant] = 1'b1;
  end

  assign w_issue_clr = (r_state == S_ISSUE) ? w_grant_oh : '0;
  assign w_grant     = (r_state == S_IDLE) && w_sel_vld && i_eng_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (i_eng_done || w_timeout) w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A new request on the issue edge survives the clear, so it re-queues.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_ptr      <= GW'(N_GHOSTS - 1);
      r_grant    <= '0;
      r_eng_curr <= '0;
      r_eng_tgt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= ((r_pending & ~w_issue_clr) | (i_req & i_ghost_en)) & i_ghost_en;
      if (w_grant) begin
        r_grant    <= w_sel;
        r_eng_curr <= i_cur_pos[int'(w_sel)*POS_W +: POS_W];
        r_eng_tgt  <= i_tgt_pos[int'(w_sel)*POS_W +: POS_W];
      end
      if (r_state == S_WRITE) r_ptr <= r_grant;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < N_GHOSTS; i++) r_next_pos[i] <= RESET_POS;
    end else if (r_state == S_WAIT) begin
      if (i_eng_done)     r_next_pos[r_grant] <= i_eng_next;
      else if (w_timeout) r_next_pos[r_grant] <= r_eng_curr;
    end
  end

`ifdef ENG_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1) + 1;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_err_timeout;

  assign w_timeout = (r_state == S_WAIT) && !i_eng_done && (r_wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wait_cnt    <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_wait_cnt <= '0;
      else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      if (w_timeout) r_err_timeout <= 1'b1;
    end
  end

  assign o_err_timeout = r_err_timeout;
`else
  localparam int CNT_W = $clog2(TIMEOUT + 1) + 1;
  logic [CNT_W-1:0] w_unused_timeout;
  assign w_unused_timeout = CNT_W'(TIMEOUT);
  assign w_timeout        = 1'b0;
  assign o_err_timeout    = 1'b0;
`endif

  for (genvar g = 0; g < N_GHOSTS; g++) begin : g_pack
    assign o_next_pos[g*POS_W +: POS_W] = r_next_pos[g];
  end

  assign o_eng_start = (r_state == S_ISSUE);
  assign o_eng_curr  = r_eng_curr;
  assign o_eng_tgt   = r_eng_tgt;
  assign o_upd_valid = (r_state == S_WRITE) ? w_grant_oh : '0;
  assign o_grant_id  = r_grant;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_ghost_move_scheduler.sv
// Directed bench for ghost_move_scheduler with a small latency-programmable engine model.
module tb_ghost_move_scheduler;
  localparam int N  = 4;
  localparam int PW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, en;
  logic [N*PW-1:0] cur, tgt;
  logic            eng_start;
  logic [PW-1:0]   eng_curr, eng_tgt;
  logic [PW-1:0]   eng_next = '0;
  logic            eng_done = 1'b0;
  logic            eng_ready;
  logic [N*PW-1:0] next_pos;
  logic [N-1:0]    upd;
  logic [1:0]      gid;
  logic            busy, err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int eng_lat = 3;
  bit mdl_never = 0;
  bit spur = 0;
  int mdl_cnt = 0;
  logic [PW-1:0] mdl_res = '0;
  int q_log[$];
  int mon_bad = 0;
  int mon_starts = 0;

  ghost_move_scheduler #(.N_GHOSTS(N), .POS_W(PW), .RESET_POS(10'd0), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_ghost_en(en),
    .i_cur_pos(cur), .i_tgt_pos(tgt),
    .o_eng_start(eng_start), .o_eng_curr(eng_curr), .o_eng_tgt(eng_tgt),
    .i_eng_next(eng_next), .i_eng_done(eng_done), .i_eng_ready(eng_ready),
    .o_next_pos(next_pos), .o_upd_valid(upd), .o_grant_id(gid),
    .o_busy(busy), .o_err_timeout(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Engine: answers eng_curr+1 eng_lat cycles after seeing start.
  always @(negedge clk) begin
    eng_done = 1'b0;
    if (rst) mdl_cnt = 0;
    else begin
      if (mdl_cnt > 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0) begin eng_done = 1'b1; eng_next = mdl_res; end
      end
      if (eng_start && !mdl_never) begin mdl_cnt = eng_lat; mdl_res = eng_curr + 10'd1; end
      if (spur) begin eng_done = 1'b1; eng_next = 10'h3FF; end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (eng_start) mon_starts++;
      if (upd != '0) begin
        if ($countones(upd) != 1) mon_bad++;
        for (int i = 0; i < N; i++) if (upd[i]) q_log.push_back(i);
      end
    end
  end

  function automatic logic [PW-1:0] np(input int i);
    return next_pos[i*PW +: PW];
  endfunction

  function automatic logic [PW-1:0] cp(input int i);
    return cur[i*PW +: PW];
  endfunction

  task automatic reset_dut();
    rst = 1'b1; req = '0; en = '0; eng_ready = 1'b1;
    spur = 0; mdl_never = 0; eng_lat = 3;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_req(input logic [N-1:0] m);
    req = m;
    @(negedge clk);
    req = '0;
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (eng_start) begin ok = 1; break; end
    end
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (q_log.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic wait_upd(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (upd != '0) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; en = 4'hF; eng_ready = 1'b1;
    @(negedge clk); #1;
    tests++; if ({busy, eng_start, err} !== 3'b000) begin fails++; $display("FAIL reset_ctrl got=%b exp=000", {busy, eng_start, err}); end
    tests++; if ({upd, gid} !== 6'd0) begin fails++; $display("FAIL reset_upd_gid got=%h exp=0", {upd, gid}); end
    tests++; if ({eng_curr, eng_tgt} !== 20'd0) begin fails++; $display("FAIL reset_eng_pos got=%h exp=0", {eng_curr, eng_tgt}); end
    tests++; if (next_pos !== '0) begin fails++; $display("FAIL reset_next_pos got=%h exp=0", next_pos); end
  endtask

  task automatic test_single();
    bit ok; int t0;
    reset_dut(); en = 4'hF;
    pulse_req(4'b0001);
    wait_start(10, ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_start got=none exp=eng_start"); end
    tests++; if ({eng_curr, eng_tgt, gid} !== {10'h021, 10'h3E0, 2'd0}) begin
      fails++; $display("FAIL single_issue got=%h/%h/%0d exp=021/3e0/0", eng_curr, eng_tgt, gid); end
    t0 = cyc;
    @(negedge clk);
    tests++; if (eng_start !== 1'b0) begin fails++; $display("FAIL single_start_width got=%b exp=0", eng_start); end
    wait_upd(20, ok);
    tests++; if (!ok || upd !== 4'b0001 || (cyc - t0) != 4) begin
      fails++; $display("FAIL single_upd got=%b lat=%0d exp=0001 lat=4", upd, cyc - t0); end
    tests++; if ({np(3), np(2), np(1), np(0)} !== {30'd0, 10'h022}) begin
      fails++; $display("FAIL single_next_pos got=%h exp=%h", next_pos, {30'd0, 10'h022}); end
    @(negedge clk);
    tests++; if (upd !== 4'b0000) begin fails++; $display("FAIL single_upd_width got=%b exp=0000", upd); end
  endtask

  task automatic test_round_robin();
    bit ok; int b; logic [7:0] got4; logic [3:0] got2; logic [N*PW-1:0] expv;
    reset_dut(); en = 4'hF;
    b = q_log.size();
    pulse_req(4'hF);
    wait_log(b + 4, 80, ok);
    got4 = ok ? {2'(q_log[b]), 2'(q_log[b+1]), 2'(q_log[b+2]), 2'(q_log[b+3])} : 8'hXX;
    tests++; if (got4 !== 8'b00_01_10_11) begin fails++; $display("FAIL rr_order4 got=%b exp=00011011", got4); end
    for (int i = 0; i < N; i++) expv[i*PW +: PW] = cp(i) + 10'd1;
    tests++; if (next_pos !== expv) begin fails++; $display("FAIL rr_next_pos got=%h exp=%h", next_pos, expv); end
    repeat (3) @(negedge clk);
    b = q_log.size();
    pulse_req(4'b1001);
    wait_log(b + 2, 40, ok);
    got2 = ok ? {2'(q_log[b]), 2'(q_log[b+1])} : 4'hX;
    tests++; if (got2 !== 4'b00_11) begin fails++; $display("FAIL rr_order2 got=%b exp=0011", got2); end
    tests++; if (mon_bad != 0) begin fails++; $display("FAIL rr_onehot got=%0d exp=0", mon_bad); end
  endtask

  task automatic test_fairness();
    bit ok; int b; logic [5:0] got;
    reset_dut(); en = 4'hF;
    b = q_log.size();
    req = 4'b0001; @(negedge clk);
    req = 4'b0101; @(negedge clk);
    req = 4'b0001;
    wait_log(b + 3, 60, ok);
    req = '0;
    got = ok ? {2'(q_log[b]), 2'(q_log[b+1]), 2'(q_log[b+2])} : 6'hXX;
    tests++; if (got !== 6'b00_10_00) begin fails++; $display("FAIL fair_order got=%b exp=001000", got); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_disable();
    bit ok; int b; int s0;
    reset_dut(); en = 4'hF; eng_ready = 1'b0;
    b = q_log.size(); s0 = mon_starts;
    req = 4'b0010; @(negedge clk);
    req = '0; en = 4'b1101; @(negedge clk);
    en = 4'hF; eng_ready = 1'b1;
    repeat (20) @(negedge clk);
    tests++; if ((mon_starts - s0) != 0 || q_log.size() != b) begin
      fails++; $display("FAIL dis_pre_grant got=starts%0d upd%0d exp=0/0", mon_starts - s0, q_log.size() - b); end
    eng_lat = 6;
    pulse_req(4'b0010);
    wait_start(10, ok);
    @(negedge clk);
    en = 4'b1101;
    wait_log(b + 1, 20, ok);
    en = 4'hF;
    tests++; if (!ok || q_log[b] != 1 || np(1) !== 10'h043) begin
      fails++; $display("FAIL dis_in_wait got=ok%0d np1=%h exp=ok1 np1=043", ok, np(1)); end
  endtask

  task automatic test_handshake();
    bit ok; int b; int s0;
    reset_dut(); en = 4'hF; eng_ready = 1'b0;
    b = q_log.size(); s0 = mon_starts;
    pulse_req(4'b0100);
    repeat (10) @(negedge clk);
    tests++; if ((mon_starts - s0) != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL hs_not_ready got=starts%0d busy%b exp=0/0", mon_starts - s0, busy); end
    spur = 1; repeat (2) @(negedge clk); spur = 0;
    repeat (3) @(negedge clk);
    tests++; if (q_log.size() != b || next_pos !== '0) begin
      fails++; $display("FAIL hs_spurious_done got=upd%0d np=%h exp=0/0", q_log.size() - b, next_pos); end
    eng_ready = 1'b1;
    wait_log(b + 1, 20, ok);
    tests++; if (!ok || q_log[b] != 2 || np(2) !== 10'h064) begin
      fails++; $display("FAIL hs_after_ready got=ok%0d np2=%h exp=ok1 np2=064", ok, np(2)); end
  endtask

  task automatic test_reset_in_wait();
    bit ok; int b; int s0;
    reset_dut(); en = 4'hF;
    b = q_log.size();
    pulse_req(4'b0010);
    wait_log(b + 1, 20, ok);
    mdl_never = 1;
    pulse_req(4'b1000);
    wait_start(10, ok);
    pulse_req(4'b0100);
    repeat (12) @(negedge clk);
`ifndef ENG_TIMEOUT_EN
    tests++; if ({busy, err, gid} !== {1'b1, 1'b0, 2'd3}) begin
      fails++; $display("FAIL riw_long_wait got=busy%b err%b gid%0d exp=1/0/3", busy, err, gid); end
`endif
    rst = 1'b1; #1;
    tests++; if ({busy, eng_start, upd} !== 6'd0 || next_pos !== '0) begin
      fails++; $display("FAIL riw_async got=%b np=%h exp=0 np=0", {busy, eng_start, upd}, next_pos); end
    @(negedge clk);
    rst = 1'b0; mdl_never = 0; s0 = mon_starts;
    repeat (15) @(negedge clk);
    tests++; if ((mon_starts - s0) != 0 || busy !== 1'b0) begin
      fails++; $display("FAIL riw_pending_cleared got=starts%0d busy%b exp=0/0", mon_starts - s0, busy); end
  endtask

`ifdef ENG_TIMEOUT_EN
  task automatic test_timeout();
    bit ok; int t0;
    reset_dut(); en = 4'hF; mdl_never = 1;
    pulse_req(4'b0010);
    wait_start(10, ok);
    t0 = cyc;
    wait_upd(30, ok);
    tests++; if (!ok || upd !== 4'b0010 || (cyc - t0) != 9) begin
      fails++; $display("FAIL to_write got=%b lat=%0d exp=0010 lat=9", upd, cyc - t0); end
    tests++; if (np(1) !== 10'h042 || err !== 1'b1) begin
      fails++; $display("FAIL to_hold got=np1=%h err%b exp=042/1", np(1), err); end
    mdl_never = 0;
    pulse_req(4'b0001);
    repeat (15) @(negedge clk);
    tests++; if (err !== 1'b1 || np(0) !== 10'h022) begin
      fails++; $display("FAIL to_sticky got=err%b np0=%h exp=1/022", err, np(0)); end
  endtask
`endif

  initial begin
    rst = 1'b1; req = '0; en = '0; eng_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      cur[i*PW +: PW] = {5'(i + 1), 5'(i + 1)};
      tgt[i*PW +: PW] = 10'h3E0 - 10'(i);
    end
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_disable();
    test_handshake();
    test_reset_in_wait();
`ifdef ENG_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
